// File: rtl/pic10_controller.sv
// PIC10 baseline-core sequencer: RESET/FLUSH/RUN/SLEEP FSM with combinational decode of the IR word.
// Optional CALL/RETLW support is compiled in when PIC10_CALL_EN is defined.
module pic10_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] ir_reg_bus,
  input  logic        alu_zero,
  input  logic        tested_bit,
  input  logic        wake,
  output logic        load_ir_reg,
  output logic        nop_sel,
  output logic        inc_pc,
  output logic        load_pc,
  output logic [1:0]  pc_sel,
  output logic        push_stack,
  output logic        pop_stack,
  output logic        load_w_reg,
  output logic        load_ram_reg,
  output logic        alu_src_lit,
  output logic        status_we,
  output logic        load_option,
  output logic        load_tris
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2,
    ST_SLEEP = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic op_byte_d, op_movwf, op_clrw, op_clrf;
  logic op_swapf, op_decfsz, op_incfsz;
  logic op_bcf, op_bsf, op_btfsc, op_btfss;
  logic op_goto, op_lit, op_movlw;
  logic op_option, op_sleep, op_tris;
  logic op_retlw, op_call;
  logic skip;

  // Instruction classification; codes not matched here fall through as NOP.
  always_comb begin
    op_byte_d = (ir_reg_bus[11:10] == 2'b00) && (ir_reg_bus[9:7] != 3'b000);
    op_movwf  = (ir_reg_bus[11:5] == 7'b0000001);
    op_clrw   = (ir_reg_bus == 12'h040);
    op_clrf   = (ir_reg_bus[11:5] == 7'b0000011);
    op_swapf  = (ir_reg_bus[11:6] == 6'b001110);
    op_decfsz = (ir_reg_bus[11:6] == 6'b001011);
    op_incfsz = (ir_reg_bus[11:6] == 6'b001111);
    op_bcf    = (ir_reg_bus[11:8] == 4'h4);
    op_bsf    = (ir_reg_bus[11:8] == 4'h5);
    op_btfsc  = (ir_reg_bus[11:8] == 4'h6);
    op_btfss  = (ir_reg_bus[11:8] == 4'h7);
    op_goto   = (ir_reg_bus[11:9] == 3'b101);
    op_lit    = (ir_reg_bus[11:10] == 2'b11);
    op_movlw  = (ir_reg_bus[11:8] == 4'hC);
    op_option = (ir_reg_bus == 12'h002);
    op_sleep  = (ir_reg_bus == 12'h003);
    op_tris   = (ir_reg_bus[11:3] == 9'd0) && (ir_reg_bus[2:0] >= 3'd5);
`ifdef PIC10_CALL_EN
    op_retlw  = (ir_reg_bus[11:8] == 4'h8);
    op_call   = (ir_reg_bus[11:8] == 4'h9);
`else
    op_retlw  = 1'b0;
    op_call   = 1'b0;
`endif
    skip = ((op_decfsz | op_incfsz) & alu_zero)
         | (op_btfsc & ~tested_bit)
         | (op_btfss & tested_bit);
  end

  always_comb begin
    state_d      = state_q;
    load_ir_reg  = 1'b0;
    nop_sel      = 1'b0;
    inc_pc       = 1'b0;
    load_pc      = 1'b0;
    pc_sel       = 2'b00;
    push_stack   = 1'b0;
    pop_stack    = 1'b0;
    load_w_reg   = 1'b0;
    load_ram_reg = 1'b0;
    alu_src_lit  = 1'b0;
    status_we    = 1'b0;
    load_option  = 1'b0;
    load_tris    = 1'b0;

    case (state_q)
      ST_RESET: state_d = ST_FLUSH;

      ST_FLUSH: begin
        load_ir_reg = 1'b1;
        inc_pc      = 1'b1;
        state_d     = ST_RUN;
      end

      ST_SLEEP: begin
        if (wake) state_d = ST_RUN;
      end

      ST_RUN: begin
        load_ir_reg = 1'b1;
        inc_pc      = 1'b1;
        state_d     = ST_RUN;

        if (op_byte_d) begin
          load_ram_reg = ir_reg_bus[5];
          load_w_reg   = ~ir_reg_bus[5];
        end
        if (op_movwf | op_clrf | op_bcf | op_bsf) load_ram_reg = 1'b1;
        if (op_clrw) load_w_reg = 1'b1;
        if (op_lit) begin
          load_w_reg  = 1'b1;
          alu_src_lit = 1'b1;
        end
        load_option = op_option;
        load_tris   = op_tris;

        // Skipped instruction is squashed by loading a NOP into the IR; writeback still happens.
        if (skip) begin
          nop_sel = 1'b1;
          state_d = ST_FLUSH;
        end

        if (op_goto) begin
          load_pc = 1'b1;
          pc_sel  = 2'b00;
          nop_sel = 1'b1;
          inc_pc  = 1'b0;
          state_d = ST_FLUSH;
        end

        if (op_call) begin
          push_stack = 1'b1;
          load_pc    = 1'b1;
          pc_sel     = 2'b01;
          nop_sel    = 1'b1;
          inc_pc     = 1'b0;
          state_d    = ST_FLUSH;
        end

        if (op_retlw) begin
          pop_stack   = 1'b1;
          load_pc     = 1'b1;
          pc_sel      = 2'b10;
          load_w_reg  = 1'b1;
          alu_src_lit = 1'b1;
          nop_sel     = 1'b1;
          inc_pc      = 1'b0;
          state_d     = ST_FLUSH;
        end

        if (op_sleep) begin
          load_ir_reg = 1'b0;
          inc_pc      = 1'b0;
          state_d     = ST_SLEEP;
        end

        // Writes that leave STATUS alone: moves, swaps, skip-counters and bit set/clear.
        status_we = (load_w_reg | load_ram_reg)
                  & ~(op_movwf | op_swapf | op_decfsz | op_incfsz
                      | op_movlw | op_retlw | op_bcf | op_bsf);
      end

      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

endmodule

// File: tb/tb_pic10_controller.sv
// Scoreboard bench for pic10_controller: mnemonic-level reference model, directed then random stimulus.
module tb_pic10_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] ir_reg_bus = 12'h000;
  logic        alu_zero = 1'b0;
  logic        tested_bit = 1'b0;
  logic        wake = 1'b0;
  logic        load_ir_reg, nop_sel, inc_pc, load_pc;
  logic [1:0]  pc_sel;
  logic        push_stack, pop_stack, load_w_reg, load_ram_reg;
  logic        alu_src_lit, status_we, load_option, load_tris;

  pic10_controller dut (
    .clk(clk), .reset(reset), .ir_reg_bus(ir_reg_bus), .alu_zero(alu_zero),
    .tested_bit(tested_bit), .wake(wake), .load_ir_reg(load_ir_reg), .nop_sel(nop_sel),
    .inc_pc(inc_pc), .load_pc(load_pc), .pc_sel(pc_sel), .push_stack(push_stack),
    .pop_stack(pop_stack), .load_w_reg(load_w_reg), .load_ram_reg(load_ram_reg),
    .alu_src_lit(alu_src_lit), .status_we(status_we), .load_option(load_option),
    .load_tris(load_tris)
  );

  always #5 clk = ~clk;

  localparam int M_RESET = 0, M_FLUSH = 1, M_RUN = 2, M_SLEEP = 3;
  int mode = M_RESET;

  logic [13:0] exp_q[$];
  string       tag_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  wire [13:0] dut_vec = {load_ir_reg, nop_sel, inc_pc, load_pc, pc_sel, push_stack, pop_stack,
                         load_w_reg, load_ram_reg, alu_src_lit, status_we, load_option, load_tris};

  function automatic string mnemonic(input logic [11:0] ir);
    int v;
    v = int'(ir);
    if (v >= 'hF00) return "XORLW";
    if (v >= 'hE00) return "ANDLW";
    if (v >= 'hD00) return "IORLW";
    if (v >= 'hC00) return "MOVLW";
    if (v >= 'hA00) return "GOTO";
    if (v >= 'h900) return "CALL";
    if (v >= 'h800) return "RETLW";
    if (v >= 'h700) return "BTFSS";
    if (v >= 'h600) return "BTFSC";
    if (v >= 'h500) return "BSF";
    if (v >= 'h400) return "BCF";
    if (v >= 'h080) begin
      case (v / 64)
        2: return "SUBWF";   3: return "DECF";    4: return "IORWF";  5: return "ANDWF";
        6: return "XORWF";   7: return "ADDWF";   8: return "MOVF";   9: return "COMF";
        10: return "INCF";   11: return "DECFSZ"; 12: return "RRF";   13: return "RLF";
        14: return "SWAPF";  default: return "INCFSZ";
      endcase
    end
    if (v >= 'h060) return "CLRF";
    if (v == 'h040) return "CLRW";
    if (v >= 'h040) return "UNDEF";
    if (v >= 'h020) return "MOVWF";
    if (v == 0) return "NOP";
    if (v == 2) return "OPTION";
    if (v == 3) return "SLEEP";
    if (v == 4) return "CLRWDT";
    if (v >= 5 && v <= 7) return "TRIS";
    return "UNDEF";
  endfunction

  // Expected outputs for the current cycle, then advance the model's mode for the next edge.
  task automatic model(input logic [11:0] ir, input logic az, input logic tb, input logic wk,
                       input logic rst, output logic [13:0] e, output string tag);
    logic lir, nop, inc, lpc, push, pop, lw, lf, lit, swe, lopt, ltris;
    logic [1:0] sel;
    string nm;
    int nxt;
    bit no_status;
    {lir, nop, inc, lpc, push, pop, lw, lf, lit, swe, lopt, ltris} = '0;
    sel = 2'b00;
    nm = mnemonic(ir);
    if (!rst) mode = M_RESET;
    nxt = mode;
    case (mode)
      M_RESET: begin nxt = M_FLUSH; nm = "reset"; end
      M_FLUSH: begin lir = 1; inc = 1; nxt = M_RUN; nm = {"flush/", nm}; end
      M_SLEEP: begin nxt = wk ? M_RUN : M_SLEEP; nm = "sleeping"; end
      default: begin
        lir = 1; inc = 1; nxt = M_RUN;
        if (int'(ir) >= 'h080 && int'(ir) < 'h400) begin
          if (ir[5]) lf = 1; else lw = 1;
        end
        if (nm == "MOVWF" || nm == "CLRF" || nm == "BCF" || nm == "BSF") lf = 1;
        if (nm == "CLRW") lw = 1;
        if (nm == "MOVLW" || nm == "IORLW" || nm == "ANDLW" || nm == "XORLW") begin
          lw = 1; lit = 1;
        end
        if (nm == "OPTION") lopt = 1;
        if (nm == "TRIS") ltris = 1;
        if (((nm == "DECFSZ" || nm == "INCFSZ") && az) || (nm == "BTFSC" && !tb) ||
            (nm == "BTFSS" && tb)) begin
          nop = 1; nxt = M_FLUSH;
        end
        if (nm == "GOTO") begin lpc = 1; sel = 2'b00; nop = 1; inc = 0; nxt = M_FLUSH; end
`ifdef PIC10_CALL_EN
        if (nm == "CALL") begin push = 1; lpc = 1; sel = 2'b01; nop = 1; inc = 0; nxt = M_FLUSH; end
        if (nm == "RETLW") begin
          pop = 1; lpc = 1; sel = 2'b10; lw = 1; lit = 1; nop = 1; inc = 0; nxt = M_FLUSH;
        end
`endif
        if (nm == "SLEEP") begin lir = 0; inc = 0; nxt = M_SLEEP; end
        no_status = (nm == "MOVWF" || nm == "SWAPF" || nm == "DECFSZ" || nm == "INCFSZ" ||
                     nm == "MOVLW" || nm == "RETLW" || nm == "BCF" || nm == "BSF");
        swe = (lw | lf) & !no_status;
      end
    endcase
    if (!rst) nxt = M_RESET;
    mode = nxt;
    e = {lir, nop, inc, lpc, sel, push, pop, lw, lf, lit, swe, lopt, ltris};
    tag = $sformatf("%s ir=%03h az=%0b tb=%0b", nm, ir, az, tb);
  endtask

  task automatic step(input logic [11:0] ir, input logic az, input logic tb, input logic wk,
                      input logic rst);
    logic [13:0] e;
    string tag;
    @(posedge clk);
    #1;
    ir_reg_bus = ir; alu_zero = az; tested_bit = tb; wake = wk; reset = rst;
    model(ir, az, tb, wk, rst, e, tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: the block answers combinationally every cycle, so each negedge pops one expectation.
  initial begin
    logic [13:0] e;
    string tag;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tag = tag_q.pop_front();
        n_vec++;
        if (dut_vec !== e || (load_w_reg && load_ram_reg) || (load_pc && inc_pc)) begin
          n_bad++;
          $display("FAIL %s got=%04h exp=%04h t=%0t", tag, dut_vec, e, $time);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] ir;
    repeat (3) step(12'h000, 0, 0, 0, 0);
    step(12'h000, 0, 0, 0, 1);
    step(12'h1E8, 0, 0, 0, 1);
    step(12'h1C0, 0, 0, 0, 1);
    step(12'h1E8, 0, 0, 0, 1);
    step(12'hC5A, 0, 0, 0, 1);
    step(12'hA05, 0, 0, 0, 1);
    step(12'h1E8, 0, 0, 0, 1);
    step(12'h2E8, 1, 0, 0, 1);
    step(12'h000, 0, 0, 0, 1);
    step(12'h2E8, 0, 0, 0, 1);
    step(12'h610, 0, 0, 0, 1);
    step(12'h000, 0, 0, 0, 1);
    step(12'h710, 0, 1, 0, 1);
    step(12'h002, 0, 0, 0, 1);
    step(12'h006, 0, 0, 0, 1);
    step(12'h003, 0, 0, 0, 1);
    repeat (10) step(12'h003, 0, 0, 0, 1);
    step(12'h003, 0, 0, 1, 1);
    step(12'h003, 0, 0, 0, 1);
    step(12'h003, 0, 0, 0, 1);
    step(12'h003, 0, 0, 1, 0);
    step(12'h000, 0, 0, 0, 1);
    step(12'h000, 0, 0, 0, 1);
    step(12'h905, 0, 0, 0, 1);
    step(12'h000, 0, 0, 0, 1);
    step(12'h8AA, 0, 0, 0, 1);
    step(12'h000, 0, 0, 0, 1);
    step(12'hA05, 0, 0, 0, 0);
    step(12'h000, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) ir = 12'($urandom_range(0, 'h7F));
      else ir = 12'($urandom_range(0, 'hFFF));
      step(ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 49) != 0));
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pic10_controller.md
PIC10_CONTROLLER -- requirements
Module: pic10_controller

Interface
REQ-001 clk  input  1  system clock; all state changes on posedge.
REQ-002 reset  input  1  asynchronous, active-low system reset.
REQ-003 ir_reg_bus  input  12  current instruction word from the IR.
REQ-004 alu_zero  input  1  high when the ALU result is 00h (skip test for DECFSZ/INCFSZ).
REQ-005 tested_bit  input  1  addressed bit of the selected file register (skip test for BTFSC/BTFSS).
REQ-006 wake  input  1  level; exits SLEEP.
REQ-007 load_ir_reg  output  1  IR captures program_mux_bus on the next posedge.
REQ-008 nop_sel  output  1  program_mux_bus is forced to 000h for this IR load.
REQ-009 inc_pc  output  1  PC increments on the next posedge.
REQ-010 load_pc  output  1  PC loads from the source selected by pc_sel.
REQ-011 pc_sel  output  2  00 = GOTO k[8:0]; 01 = CALL {0,k[7:0]}; 10 = stack top; 11 = unused.
REQ-012 push_stack, pop_stack  output  1 each  return-stack controls.
REQ-013 load_w_reg  output  1  W captures alu_bus.
REQ-014 load_ram_reg  output  1  addressed file register captures alu_bus.
REQ-015 alu_src_lit  output  1  ALU 2nd operand = IR literal k[7:0], not alu_mux_bus.
REQ-016 status_we  output  1  enables the ALU load_z/load_c/load_dc into STATUS.
REQ-017 load_option, load_tris  output  1 each  OPTION / TRIS register write from W.

Function
REQ-018 States SHALL be RESET, FLUSH, RUN and SLEEP; the state is registered and all outputs are combinational from the state, ir_reg_bus, alu_zero and tested_bit.
REQ-019 RESET SHALL drive all outputs to 0; the first posedge after reset deasserts SHALL go to FLUSH.
REQ-020 FLUSH SHALL ignore ir_reg_bus, assert load_ir_reg=1 and inc_pc=1 with every other output 0, then go to RUN.
REQ-021 RUN SHALL execute ir_reg_bus in one clock with load_ir_reg=1 and inc_pc=1 (pipelined fetch) unless REQ-024 or REQ-025 overrides.
REQ-022 Byte file ops: d=IR[5]; d=0 asserts load_w_reg, d=1 asserts load_ram_reg; MOVWF, CLRF, BCF and BSF assert load_ram_reg; CLRW asserts load_w_reg.
REQ-023 Literal ops: MOVLW/IORLW/ANDLW/XORLW assert load_w_reg and alu_src_lit; status_we=1 for every W/f write except MOVWF, SWAPF, DECFSZ, INCFSZ, MOVLW, RETLW, BCF and BSF.
REQ-024 Skip: DECFSZ/INCFSZ with alu_zero=1, BTFSC with tested_bit=0 and BTFSS with tested_bit=1 SHALL keep their writeback, assert nop_sel=1 with inc_pc=1, and go to FLUSH; otherwise they stay in RUN.
REQ-025 GOTO SHALL assert load_pc=1, pc_sel=00, load_ir_reg=1, nop_sel=1 and inc_pc=0, then go to FLUSH.
REQ-026 OPTION (002h) asserts load_option; TRIS (005h-007h) asserts load_tris; NOP, CLRWDT, TRIS 000h-001h and undefined codes assert only the fetch strobes.
REQ-027 SLEEP (003h) in RUN: fetch strobes 0, next state SLEEP; SLEEP holds all outputs 0 until a posedge with wake=1, then goes to RUN with the IR and PC untouched.
REQ-028 load_w_reg and load_ram_reg SHALL never both be 1; load_pc and inc_pc SHALL never both be 1.

Reset
REQ-029 reset=0 SHALL force RESET and zero all outputs immediately, regardless of clk, state, wake or an in-progress skip or branch.
REQ-030 The block holds no state other than the FSM register.

Configuration
REQ-031 Macro PIC10_CALL_EN defined: CALL asserts push_stack, load_pc and pc_sel=01; RETLW asserts pop_stack, load_pc, pc_sel=10, load_w_reg and alu_src_lit; both assert nop_sel, deassert inc_pc and go to FLUSH.
REQ-032 Macro PIC10_CALL_EN undefined: CALL/RETLW decode as NOP, and push_stack, pop_stack and pc_sel=01/10 are never driven.

Verification
REQ-033 Hold reset=0 for 3 clocks, then release -> all outputs 0 while low; 1st posedge: FLUSH (load_ir_reg=1, inc_pc=1, no writes); next: RUN.
REQ-034 RUN, IR=1C0h -> load_w_reg=1, status_we=1, load_ram_reg=0; IR=1E8h -> load_ram_reg=1; IR=C5Ah -> load_w_reg=1, alu_src_lit=1, status_we=0.
REQ-035 RUN, IR=A05h -> load_pc=1, pc_sel=00, nop_sel=1, inc_pc=0; next cycle (FLUSH) with IR=1E8h -> no writes.
REQ-036 RUN, IR=2E8h, alu_zero=1 -> load_ram_reg=1, nop_sel=1, then FLUSH; with alu_zero=0 -> nop_sel=0, stays in RUN; IR=610h with tested_bit=0 -> skip.
REQ-037 RUN, IR=003h -> SLEEP with all outputs 0 for 10 clocks; wake=1 -> RUN; reset=0 while in SLEEP -> RESET.
REQ-038 With PIC10_CALL_EN, IR=905h -> push_stack=1, pc_sel=01; IR=8AAh -> pop_stack=1, pc_sel=10, load_w_reg=1; without the macro both -> only load_ir_reg=1, inc_pc=1.
